// File: rtl/softplus_pipe.sv
// softplus_pipe: three-stage piecewise-linear softplus, SP(x) = ln(1 + e^x).
// Signed Q4.15 in and out (20 bits, LSB = 2^-15). Uses SP(x) = max(x,0) + g(|x|),
// where g(a) = softplus(-a) is approximated by shift-add segments over five regions.
// A single global advance enable stalls every stage together; bubbles are not collapsed.
module softplus_pipe (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [19:0] X_in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [19:0] SP_out,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam logic [2:0] RG_0 = 3'd0;
  localparam logic [2:0] RG_1 = 3'd1;
  localparam logic [2:0] RG_2 = 3'd2;
  localparam logic [2:0] RG_3 = 3'd3;
  localparam logic [2:0] RG_4 = 3'd4;

  logic adv;

  // stage 1: magnitude, positive part, region
  logic        v1_q, v1_d;
  logic [19:0] a1_q, a1_d;
  logic [19:0] pos1_q, pos1_d;
  logic [2:0]  rg1_q, rg1_d;
  logic [19:0] abs_x;
  logic [2:0]  rg_x;

  // stage 2: correction term g
  logic        v2_q, v2_d;
  logic [19:0] pos2_q, pos2_d;
  logic [19:0] g2_q, g2_d;
  logic signed [20:0] a_x;
  logic signed [20:0] g_raw;

  // stage 3: final sum
  logic        v3_q, v3_d;
  logic [19:0] sp3_q, sp3_d;
  logic [20:0] s_sum;

  // Global advance: the tail can move if it is empty or being consumed
  always_comb begin
    adv      = !v3_q || out_ready;
    in_ready = adv;
  end

  // Stage 1 next state: saturated |x| (most-negative input maps to max positive), region select
  always_comb begin
    v1_d   = v1_q;
    a1_d   = a1_q;
    pos1_d = pos1_q;
    rg1_d  = rg1_q;
    if (X_in[19]) begin
      abs_x = (X_in == 20'h80000) ? 20'h7FFFF : (~X_in + 20'd1);
    end else begin
      abs_x = X_in;
    end
    if (abs_x < 20'h08000)      rg_x = RG_0;
    else if (abs_x < 20'h10000) rg_x = RG_1;
    else if (abs_x < 20'h20000) rg_x = RG_2;
    else if (abs_x < 20'h40000) rg_x = RG_3;
    else                        rg_x = RG_4;
    if (adv) begin
      v1_d   = in_valid;
      a1_d   = abs_x;
      pos1_d = X_in[19] ? 20'h00000 : X_in;
      rg1_d  = rg_x;
    end
  end

  // Stage 2 next state: segment evaluation of g, clamped at zero
  always_comb begin
    v2_d   = v2_q;
    pos2_d = pos2_q;
    g2_d   = g2_q;
    a_x    = $signed({1'b0, a1_q});
    case (rg1_q)
      RG_0:    g_raw = 21'sh058B9 - (a_x >>> 1) + (a_x >>> 3);
      RG_1:    g_raw = 21'sh0401A - (a_x >>> 3) - (a_x >>> 4);
      RG_2:    g_raw = 21'sh01E3F - (a_x >>> 4) + (a_x >>> 7);
      RG_3:    g_raw = 21'sh00493 - (a_x >>> 8) - (a_x >>> 11);
      default: g_raw = 21'sh00000;
    endcase
    if (adv) begin
      v2_d   = v1_q;
      pos2_d = pos1_q;
      g2_d   = g_raw[20] ? 20'h00000 : g_raw[19:0];
    end
  end

  // Stage 3 next state: sum with top saturation and a floor of one LSB so dev never sees <= 0
  always_comb begin
    v3_d  = v3_q;
    sp3_d = sp3_q;
    s_sum = {1'b0, pos2_q} + {1'b0, g2_q};
    if (adv) begin
      v3_d = v2_q;
      if (s_sum > 21'h07FFFF)  sp3_d = 20'h7FFFF;
      else if (s_sum < 21'd1)  sp3_d = 20'h00001;
      else                     sp3_d = s_sum[19:0];
    end
  end

  // Pipeline registers; reset flushes every stage asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      a1_q   <= 20'h00000;
      pos1_q <= 20'h00000;
      rg1_q  <= RG_0;
      v2_q   <= 1'b0;
      pos2_q <= 20'h00000;
      g2_q   <= 20'h00000;
      v3_q   <= 1'b0;
      sp3_q  <= 20'h00000;
    end else begin
      v1_q   <= v1_d;
      a1_q   <= a1_d;
      pos1_q <= pos1_d;
      rg1_q  <= rg1_d;
      v2_q   <= v2_d;
      pos2_q <= pos2_d;
      g2_q   <= g2_d;
      v3_q   <= v3_d;
      sp3_q  <= sp3_d;
    end
  end

  // Output view of the last stage
  always_comb begin
    SP_out    = sp3_q;
    out_valid = v3_q;
  end

endmodule

// File: tb/tb_softplus_pipe.sv
// Directed and randomized bench for softplus_pipe with a queue scoreboard.
module tb_softplus_pipe;

  logic        clk;
  logic        rst_n;
  logic [19:0] X_in;
  logic        in_valid;
  logic        in_ready;
  logic [19:0] SP_out;
  logic        out_valid;
  logic        out_ready;

  int checks   = 0;
  int failures = 0;
  int n_accept = 0;
  bit rand_mode = 1'b0;
  logic [19:0] sb[$];
  logic [19:0] bp[5];

  softplus_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .X_in      (X_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .SP_out    (SP_out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model written directly from the piecewise definition
  function automatic logic [19:0] sp_model(input logic [19:0] x);
    int xi, a, pos, g, s;
    logic [31:0] r;
    xi  = $signed(x);
    a   = (xi < 0) ? -xi : xi;
    if (a > 524287) a = 524287;
    pos = (xi > 0) ? xi : 0;
    if (a < 'h08000)      g = 'h058B9 - (a >> 1) + (a >> 3);
    else if (a < 'h10000) g = 'h0401A - (a >> 3) - (a >> 4);
    else if (a < 'h20000) g = 'h01E3F - (a >> 4) + (a >> 7);
    else if (a < 'h40000) g = 'h00493 - (a >> 8) - (a >> 11);
    else                  g = 0;
    if (g < 0) g = 0;
    s = pos + g;
    if (s > 524287) s = 524287;
    if (s < 1) s = 1;
    r = s;
    return r[19:0];
  endfunction

  task automatic check(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: handshakes seen at negedge complete on the following posedge
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_output", {19'b0, out_valid}, 20'h0);
      end else begin
        check("sb_data", SP_out, sb.pop_front());
      end
    end
    if (rst_n && in_valid && in_ready) begin
      sb.push_back(sp_model(X_in));
      n_accept++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one sample and return just after the edge that accepts it
  task automatic push_one(input logic [19:0] x);
    int guard;
    guard    = 0;
    X_in     = x;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready || guard >= 50) break;
      @(posedge clk);
      #1;
      if (rand_mode) out_ready = 1'($urandom_range(0, 1));
      guard++;
    end
    check("accept_timeout", {19'b0, guard < 50}, 20'h1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (rand_mode) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_out(input string tag, input logic [19:0] exp);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!out_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_timeout"}, {19'b0, guard < 20}, 20'h1);
    check(tag, SP_out, exp);
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    @(negedge clk);
    while ((sb.size() != 0 || out_valid) && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    check("drain_timeout", {19'b0, guard < 300}, 20'h1);
  endtask

  initial begin
    int base;
    rst_n     = 1'b0;
    X_in      = 20'h00000;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    bp[0] = 20'h01000; bp[1] = 20'hFC000; bp[2] = 20'h18000;
    bp[3] = 20'h30000; bp[4] = 20'hE0000;

    // reset values
    repeat (3) @(negedge clk);
    check("rst_out_valid", {19'b0, out_valid}, 20'h0);
    check("rst_sp_out", SP_out, 20'h00000);
    check("rst_in_ready", {19'b0, in_ready}, 20'h1);
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_in_ready", {19'b0, in_ready}, 20'h1);

    // single zero sample: three-cycle latency
    push_one(20'h00000);
    @(negedge clk);
    check("lat_c1_valid", {19'b0, out_valid}, 20'h0);
    @(negedge clk);
    check("lat_c2_valid", {19'b0, out_valid}, 20'h0);
    @(negedge clk);
    check("lat_c3_valid", {19'b0, out_valid}, 20'h1);
    check("lat_c3_data", SP_out, 20'h058B9);

    // back-to-back stream, results on consecutive cycles
    step();
    push_one(20'h08000);
    push_one(20'hF8000);
    push_one(20'hA0000);
    @(negedge clk);
    check("stream0_valid", {19'b0, out_valid}, 20'h1);
    check("stream0", SP_out, 20'h0A81A);
    @(negedge clk);
    check("stream1_valid", {19'b0, out_valid}, 20'h1);
    check("stream1", SP_out, 20'h0281A);
    @(negedge clk);
    check("stream2_valid", {19'b0, out_valid}, 20'h1);
    check("stream2", SP_out, 20'h00001);

    // extremes
    step();
    push_one(20'h7FFFF);
    push_one(20'h80000);
    wait_out("ext_pos", 20'h7FFFF);
    wait_out("ext_neg", 20'h00001);

    // region boundary R0/R1 on the negative side
    step();
    push_one(20'hF8001);
    push_one(20'hF8000);
    wait_out("bnd_r0", 20'h028B9);
    wait_out("bnd_r1", 20'h0281A);
    wait_drain();

    // backpressure: only three fit while the output is blocked
    step();
    out_ready = 1'b0;
    base = n_accept;
    push_one(bp[0]);
    push_one(bp[1]);
    push_one(bp[2]);
    X_in     = bp[3];
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready", {19'b0, in_ready}, 20'h0);
      check("bp_out_valid", {19'b0, out_valid}, 20'h1);
      check("bp_hold", SP_out, sp_model(bp[0]));
    end
    check("bp_accepted", 20'(n_accept - base), 20'd3);
    step();
    out_ready = 1'b1;
    push_one(bp[3]);
    push_one(bp[4]);
    wait_drain();
    check("bp_total", 20'(n_accept - base), 20'd5);

    // random stream with random output stalls
    step();
    rand_mode = 1'b1;
    for (int i = 0; i < 40; i++) begin
      push_one(20'($urandom_range(0, 20'hFFFFF)));
    end
    rand_mode = 1'b0;
    out_ready = 1'b1;
    wait_drain();

    // asynchronous reset with samples in flight
    step();
    out_ready = 1'b0;
    push_one(20'h04000);
    push_one(20'hF0000);
    push_one(20'h20000);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {19'b0, out_valid}, 20'h0);
    check("midrst_sp_out", SP_out, 20'h00000);
    sb.delete();
    repeat (2) @(posedge clk);
    #2;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_rst_no_stale", {19'b0, out_valid}, 20'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
